// File: rtl/temp_scancode_tx_if.sv
// ============================================================================
// Module   : temp_scancode_tx_if
// Purpose  : Request/status and emulated PS/2 line bundle for temp_scancode_tx.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface temp_scancode_tx_if;
    logic [6:0] TEMP_IN;
    logic       start;
    logic       ps2_clk;
    logic       ps2_data;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output TEMP_IN,
        output start,
        input  ps2_clk,
        input  ps2_data,
        input  busy,
        input  done,
        input  err
    );

    modport slave (
        input  TEMP_IN,
        input  start,
        output ps2_clk,
        output ps2_data,
        output busy,
        output done,
        output err
    );
endinterface

`default_nettype wire

// File: rtl/temp_scancode_tx.sv
// ============================================================================
// Module   : temp_scancode_tx
// Purpose  : Sends a 0..99 temperature as two-digit PS/2 make/break frames.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module temp_scancode_tx #(
    parameter int HALF_BIT = 25000,
    parameter int GAP      = 50000
) (
    input  wire logic          CLK,
    input  wire logic          reset,
    temp_scancode_tx_if.slave  bus
);

    localparam int CNT_MAX = (HALF_BIT > GAP) ? HALF_BIT : GAP;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] c_hb_last  = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] c_gap_last = CW'(GAP - 1);
    localparam logic [3:0]    c_bit_last = 4'd10;
    localparam logic [2:0]    c_idx_last = 3'd5;
    localparam logic [7:0]    c_break    = 8'hF0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_BIT_HI = 3'd2,
        S_BIT_LO = 3'd3,
        S_GAP    = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [3:0]     bit_q, bit_d;
    logic [2:0]     idx_q, idx_d;
    logic [10:0]    shift_q, shift_d;
    logic [7:0]     tcode_q, tcode_d;
    logic [7:0]     ucode_q, ucode_d;
    logic           ps2_clk_q, ps2_clk_d;
    logic           ps2_data_q, ps2_data_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;

    logic [6:0]     w_tens;
    logic [6:0]     w_units;
    logic [7:0]     w_byte;

    function automatic logic [7:0] code_of(input logic [6:0] digit);
        logic [7:0] code;
        case (digit)
            7'd0:    code = 8'h45;
            7'd1:    code = 8'h16;
            7'd2:    code = 8'h1E;
            7'd3:    code = 8'h26;
            7'd4:    code = 8'h25;
            7'd5:    code = 8'h2E;
            7'd6:    code = 8'h36;
            7'd7:    code = 8'h3D;
            7'd8:    code = 8'h3E;
            7'd9:    code = 8'h46;
            default: code = 8'h45;
        endcase
        return code;
    endfunction

    // Comparison chain instead of a divider: the last threshold passed wins.
    always_comb begin
        w_tens  = 7'd0;
        w_units = bus.TEMP_IN;
        for (int k = 1; k <= 9; k++) begin
            if (bus.TEMP_IN >= 7'(10 * k)) begin
                w_tens  = 7'(k);
                w_units = bus.TEMP_IN - 7'(10 * k);
            end
        end
    end

    always_comb begin
        case (idx_q)
            3'd0, 3'd2: w_byte = tcode_q;
            3'd1, 3'd4: w_byte = c_break;
            default:    w_byte = ucode_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tcode_d = tcode_q;
        ucode_d = ucode_q;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.TEMP_IN <= 7'd99) begin
                        tcode_d = code_of(w_tens);
                        ucode_d = code_of(w_units);
                        idx_d   = 3'd0;
                        cnt_d   = '0;
                        state_d = S_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_LOAD: begin
                // Shifted out LSB first: start, data[0..7], odd parity, stop.
                shift_d = {1'b1, ~^w_byte, w_byte, 1'b0};
                bit_d   = 4'd0;
                cnt_d   = '0;
                state_d = S_BIT_HI;
            end

            S_BIT_HI: begin
                if (cnt_q == c_hb_last) begin
                    cnt_d   = '0;
                    state_d = S_BIT_LO;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_BIT_LO: begin
                if (cnt_q == c_hb_last) begin
                    cnt_d = '0;
                    if (bit_q == c_bit_last) begin
                        state_d = S_GAP;
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        shift_d = {1'b1, shift_q[10:1]};
                        state_d = S_BIT_HI;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_GAP: begin
                if (cnt_q == c_gap_last) begin
                    cnt_d = '0;
                    if (idx_q == c_idx_last) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so the lines never glitch.
        busy_d     = (state_d == S_LOAD) || (state_d == S_BIT_HI) ||
                     (state_d == S_BIT_LO) || (state_d == S_GAP);
        done_d     = (state_d == S_DONE);
        ps2_clk_d  = (state_d != S_BIT_LO);
        ps2_data_d = ((state_d == S_BIT_HI) || (state_d == S_BIT_LO)) ? shift_d[0] : 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= 4'd0;
            idx_q      <= 3'd0;
            shift_q    <= '0;
            tcode_q    <= 8'h00;
            ucode_q    <= 8'h00;
            ps2_clk_q  <= 1'b1;
            ps2_data_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            tcode_q    <= tcode_d;
            ucode_q    <= ucode_d;
            ps2_clk_q  <= ps2_clk_d;
            ps2_data_q <= ps2_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.ps2_clk  = ps2_clk_q;
    assign bus.ps2_data = ps2_data_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_temp_scancode_tx.sv
// ============================================================================
// Module   : tb_temp_scancode_tx
// Purpose  : Scoreboard bench: expected PS/2 bytes queued at start, frames decoded on ps2_clk falls.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_temp_scancode_tx;

    localparam int HB   = 4;
    localparam int GP   = 8;
    localparam int XFER = 6 * (22 * HB + GP + 1) + 1;

    typedef struct packed {
        logic [7:0] code;
        logic       par;
    } exp_t;

    logic CLK   = 1'b0;
    logic reset = 1'b1;

    temp_scancode_tx_if bus();

    temp_scancode_tx #(
        .HALF_BIT (HB),
        .GAP      (GP)
    ) u_dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    exp_t        exp_q[$];
    int          total      = 0;
    int          bad        = 0;
    int          mon_frames = 0;
    int          mon_bits   = 0;
    bit          chk_first  = 1'b0;
    logic [10:0] first_exp  = 11'b11000111100;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic push_seq(input logic [7:0] t, input logic pt, input logic [7:0] u, input logic pu);
        exp_q.push_back(exp_t'({t, pt}));
        exp_q.push_back(exp_t'({8'hF0, 1'b1}));
        exp_q.push_back(exp_t'({t, pt}));
        exp_q.push_back(exp_t'({u, pu}));
        exp_q.push_back(exp_t'({8'hF0, 1'b1}));
        exp_q.push_back(exp_t'({u, pu}));
    endtask

    // Monitor: decode frames on each ps2_clk falling edge and score them.
    initial begin : monitor
        logic        prev;
        logic [10:0] fr;
        exp_t        e;
        prev = 1'b1;
        fr   = '0;
        forever begin
            @(negedge CLK);
            if (reset) begin
                mon_bits = 0;
                prev     = 1'b1;
            end else begin
                if (prev && !bus.ps2_clk) begin
                    fr[mon_bits] = bus.ps2_data;
                    mon_bits++;
                    if (mon_bits == 11) begin
                        mon_bits = 0;
                        mon_frames++;
                        if (exp_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_frame: got %0h want none", fr);
                        end else begin
                            e = exp_q.pop_front();
                            check("frame_start",  32'(fr[0]),   32'd0);
                            check("frame_stop",   32'(fr[10]),  32'd1);
                            check("frame_byte",   32'(fr[8:1]), 32'(e.code));
                            check("frame_parity", 32'(fr[9]),   32'(e.par));
                            if (chk_first) begin
                                chk_first = 1'b0;
                                check("first_frame_bits", 32'(fr), 32'(first_exp));
                            end
                        end
                    end
                end
                prev = bus.ps2_clk;
            end
        end
    end

    task automatic run_xfer(input logic [6:0] temp, input bit inject);
        int busy_n;
        int done_at;
        int extra;
        logic busy_at_done;
        busy_n       = 0;
        done_at      = 0;
        extra        = 0;
        busy_at_done = 1'b1;
        @(negedge CLK);
        #2 bus.TEMP_IN = temp;
        bus.start = 1'b1;
        for (int n = 1; (n <= XFER + 50) && (done_at == 0); n++) begin
            @(negedge CLK);
            if (bus.done) begin
                done_at      = n;
                busy_at_done = bus.busy;
            end else if (bus.busy) begin
                busy_n++;
            end
            if (n == 1) begin
                #2 bus.start = 1'b0;
            end
            if (inject && n == 100) begin
                #2 bus.TEMP_IN = 7'd50;
                bus.start = 1'b1;
            end
            if (inject && n == 101) begin
                #2 bus.start = 1'b0;
                bus.TEMP_IN = temp;
            end
        end
        check("done_latency",  32'(done_at), 32'(XFER));
        check("busy_cycles",   32'(busy_n),  32'(XFER - 1));
        check("busy_at_done",  32'(busy_at_done), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        repeat (20) begin
            @(negedge CLK);
            if (bus.done || bus.busy || !bus.ps2_clk) extra++;
        end
        check("quiet_after_done", 32'(extra), 32'd0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int   cnt;
        int   base;
        bit   found;
        bus.TEMP_IN = 7'd0;
        bus.start   = 1'b0;
        reset       = 1'b1;

        repeat (3) @(negedge CLK);
        check("reset_state", 32'({bus.ps2_clk, bus.ps2_data, bus.busy, bus.done, bus.err}), 32'b11000);
        #2 reset = 1'b0;
        repeat (20) begin
            @(negedge CLK);
            check("idle_lines", 32'({bus.ps2_clk, bus.ps2_data, bus.busy, bus.done, bus.err}), 32'b11000);
        end

        // 25 -> 1E,F0,1E,2E,F0,2E, all parity 1
        push_seq(8'h1E, 1'b1, 8'h2E, 1'b1);
        chk_first = 1'b1;
        run_xfer(7'd25, 1'b0);

        push_seq(8'h45, 1'b0, 8'h45, 1'b0);
        run_xfer(7'd0, 1'b0);
        push_seq(8'h46, 1'b0, 8'h46, 1'b0);
        run_xfer(7'd99, 1'b0);
        push_seq(8'h16, 1'b0, 8'h45, 1'b0);
        run_xfer(7'd10, 1'b0);

        // Out-of-range request
        @(negedge CLK);
        #2 bus.TEMP_IN = 7'd100;
        bus.start = 1'b1;
        @(negedge CLK);
        check("err_pulse", 32'({bus.err, bus.busy}), 32'b10);
        #2 bus.start = 1'b0;
        @(negedge CLK);
        check("err_clears", 32'({bus.err, bus.busy}), 32'b00);
        cnt = 0;
        repeat (200) begin
            @(negedge CLK);
            if (!bus.ps2_clk || !bus.ps2_data || bus.busy || bus.done) cnt++;
        end
        check("err_no_activity", 32'(cnt), 32'd0);

        // Start with 50 mid-transfer of 25 must be ignored
        push_seq(8'h1E, 1'b1, 8'h2E, 1'b1);
        run_xfer(7'd25, 1'b1);

        // Reset during bit 4 of byte 2
        push_seq(8'h1E, 1'b1, 8'h2E, 1'b1);
        base = mon_frames;
        @(negedge CLK);
        #2 bus.TEMP_IN = 7'd25;
        bus.start = 1'b1;
        @(negedge CLK);
        #2 bus.start = 1'b0;
        found = 1'b0;
        for (int w = 0; (w < 2000) && !found; w++) begin
            @(negedge CLK);
            if (mon_frames == base + 2 && mon_bits == 4) found = 1'b1;
        end
        check("reached_byte2_bit4", 32'(found), 32'd1);
        #2 reset = 1'b1;
        @(negedge CLK);
        check("reset_midframe", 32'({bus.ps2_clk, bus.ps2_data, bus.busy}), 32'b110);
        #2 reset = 1'b0;
        exp_q.delete();
        cnt = 0;
        repeat (100) begin
            @(negedge CLK);
            if (bus.done || bus.busy || !bus.ps2_clk) cnt++;
        end
        check("no_done_after_reset", 32'(cnt), 32'd0);

        push_seq(8'h26, 1'b0, 8'h16, 1'b0);
        run_xfer(7'd31, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
